ntt_sdf_butterfly_stage: RTL and testbench

Single radix-2 single-path delay-feedback (SDF) stage of the NTT datapath. It accepts one coefficient per accepted cycle, performs the DIF butterfly against a DELAY-deep feedback line, and multiplies the difference branch by a twiddle. Every result leaves as an unreduced 2·DATA_SIZE-bit word that feeds the downstream Barrett reduction stage directly. Sum results leave zero-extended and already below PRIME; product results leave raw.

---
 rtl/ntt_sdf_butterfly_stage.sv | 129 ++++++++++++
 tb/tb_ntt_sdf_butterfly_stage.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/ntt_sdf_butterfly_stage.sv
// Radix-2 SDF DIF butterfly stage emitting unreduced words for the Barrett stage.
// Optional SDF_PIPE_MULT_EN adds a second output register (2-cycle latency).
module ntt_sdf_butterfly_stage #(
    parameter int DATA_SIZE = 64,
    parameter int PRIME     = 7681,
    parameter int DELAY     = 4,
    parameter int TW_STRIDE = 1,
    parameter int TW_AW     = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   valid_in,
    input  logic [DATA_SIZE-1:0]   data_in,
    input  logic [DATA_SIZE-1:0]   tw_data,
    output logic [TW_AW-1:0]       tw_addr,
    output logic                   valid_out,
    output logic [2*DATA_SIZE-1:0] data_out,
    output logic                   phase_out
);
    localparam int KW = $clog2(DELAY);
    localparam int CW = KW + 1;
    localparam logic [DATA_SIZE:0]   PRIME_W = (DATA_SIZE + 1)'(PRIME);
    localparam logic [DATA_SIZE-1:0] PRIME_D = DATA_SIZE'(PRIME);

    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   primed_q, primed_d;
    logic [DATA_SIZE-1:0]   dl_q [DELAY];
    logic [DATA_SIZE-1:0]   dl_d [DELAY];
    logic [DATA_SIZE-1:0]   dl_in;
    logic [DATA_SIZE-1:0]   dl_out;
    logic                   phase;
    logic [KW-1:0]          k;
    logic [31:0]            tw_idx;
    logic [DATA_SIZE:0]     sum_w;
    logic [DATA_SIZE:0]     sum_r;
    logic [DATA_SIZE-1:0]   diff;
    logic [2*DATA_SIZE-1:0] prod;
    logic                   res_valid;
    logic [2*DATA_SIZE-1:0] res_data;
    logic                   v1_q, v1_d, p1_q, p1_d;
    logic [2*DATA_SIZE-1:0] d1_q, d1_d;

    assign phase  = cnt_q[KW];
    assign k      = cnt_q[KW-1:0];
    assign dl_out = dl_q[DELAY-1];

    always_comb begin
        tw_idx  = 32'(k) * 32'(TW_STRIDE);
        tw_addr = tw_idx[TW_AW-1:0];
    end

    always_comb begin
        sum_w = {1'b0, dl_out} + {1'b0, data_in};
        sum_r = (sum_w >= PRIME_W) ? (sum_w - PRIME_W) : sum_w;
        // Modular wrap of the subtraction is cancelled by adding PRIME back.
        diff  = dl_out - data_in + ((dl_out < data_in) ? PRIME_D : '0);
        prod  = {{DATA_SIZE{1'b0}}, dl_out} * {{DATA_SIZE{1'b0}}, tw_data};
        dl_in = phase ? diff : data_in;
    end

    always_comb begin
        cnt_d     = valid_in ? cnt_q + 1'b1 : cnt_q;
        primed_d  = primed_q | (valid_in && (cnt_q == CW'(DELAY - 1)));
        res_valid = valid_in && (phase || primed_q);
        res_data  = phase ? {{DATA_SIZE{1'b0}}, sum_r[DATA_SIZE-1:0]} : prod;
        v1_d      = res_valid;
        d1_d      = res_valid ? res_data : d1_q;
        p1_d      = res_valid ? phase : p1_q;
    end

    generate
        for (genvar gi = 0; gi < DELAY; gi++) begin : g_dl
            if (gi == 0) begin : g_head
                assign dl_d[gi] = valid_in ? dl_in : dl_q[gi];
            end else begin : g_tail
                assign dl_d[gi] = valid_in ? dl_q[gi-1] : dl_q[gi];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            primed_q <= 1'b0;
            v1_q     <= 1'b0;
            d1_q     <= '0;
            p1_q     <= 1'b0;
            for (int i = 0; i < DELAY; i++) dl_q[i] <= '0;
        end else begin
            cnt_q    <= cnt_d;
            primed_q <= primed_d;
            v1_q     <= v1_d;
            d1_q     <= d1_d;
            p1_q     <= p1_d;
            for (int i = 0; i < DELAY; i++) dl_q[i] <= dl_d[i];
        end
    end

`ifdef SDF_PIPE_MULT_EN
    logic                   v2_q, v2_d, p2_q, p2_d;
    logic [2*DATA_SIZE-1:0] d2_q, d2_d;

    always_comb begin
        v2_d = v1_q;
        d2_d = v1_q ? d1_q : d2_q;
        p2_d = v1_q ? p1_q : p2_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2_q <= 1'b0;
            d2_q <= '0;
            p2_q <= 1'b0;
        end else begin
            v2_q <= v2_d;
            d2_q <= d2_d;
            p2_q <= p2_d;
        end
    end

    assign valid_out = v2_q;
    assign data_out  = d2_q;
    assign phase_out = p2_q;
`else
    assign valid_out = v1_q;
    assign data_out  = d1_q;
    assign phase_out = p1_q;
`endif
endmodule

// File: tb/tb_ntt_sdf_butterfly_stage.sv
// Randomized bench for ntt_sdf_butterfly_stage against a frame-level NTT butterfly model.
module tb_ntt_sdf_butterfly_stage;
    localparam int DATA_SIZE = 64;
    localparam int PRIME     = 7681;
    localparam int DELAY     = 4;
    localparam int TW_STRIDE = 1;
    localparam int TW_AW     = 8;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   valid_in = 1'b0;
    logic [DATA_SIZE-1:0]   data_in = '0;
    logic [DATA_SIZE-1:0]   tw_data;
    logic [TW_AW-1:0]       tw_addr;
    logic                   valid_out;
    logic [2*DATA_SIZE-1:0] data_out;
    logic                   phase_out;

    logic [DATA_SIZE-1:0] tw_rom [256];

    int n_checks = 0;
    int n_pass   = 0;

    // Frame-level model: first-half samples and previous-frame differences.
    int                     m_pos;
    bit                     m_primed;
    longint unsigned        m_first [DELAY];
    longint unsigned        m_diff  [DELAY];
    longint unsigned        m_next  [DELAY];
    logic [2*DATA_SIZE-1:0] m_last;

    ntt_sdf_butterfly_stage #(
        .DATA_SIZE(DATA_SIZE), .PRIME(PRIME), .DELAY(DELAY),
        .TW_STRIDE(TW_STRIDE), .TW_AW(TW_AW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .data_in(data_in),
        .tw_data(tw_data), .tw_addr(tw_addr), .valid_out(valid_out),
        .data_out(data_out), .phase_out(phase_out)
    );

    always #5 clk = ~clk;
    always_comb tw_data = tw_rom[tw_addr];

    task automatic check(input string tag, input logic [2*DATA_SIZE-1:0] obs,
                         input logic [2*DATA_SIZE-1:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_pos    = 0;
        m_primed = 0;
        m_last   = '0;
        for (int i = 0; i < DELAY; i++) begin
            m_first[i] = 0; m_diff[i] = 0; m_next[i] = 0;
        end
    endtask

    task automatic set_tw(input int mode);
        for (int i = 0; i < 256; i++)
            tw_rom[i] = (mode == 0) ? 64'd1 :
                        (mode == 1) ? 64'(PRIME - 1) :
                                      64'($urandom_range(0, PRIME - 1));
    endtask

    task automatic step(input bit v, input longint unsigned x);
        int                     k;
        int                     ta;
        bit                     ev;
        bit                     ep;
        logic [2*DATA_SIZE-1:0] ed;
        @(negedge clk);
        valid_in = v;
        data_in  = x;
        k  = m_pos % DELAY;
        ta = (k * TW_STRIDE) % 256;
        check("tw_addr", 128'(tw_addr), 128'(ta));
        ev = 0; ep = 0; ed = m_last;
        if (v) begin
            if (m_pos < DELAY) begin
                ev = m_primed;
                ed = 128'(m_diff[k]) * 128'(tw_rom[ta]);
                m_first[k] = x;
            end else begin
                ev = 1; ep = 1;
                ed = 128'((m_first[k] + x) % PRIME);
                m_next[k] = (m_first[k] + PRIME - x) % PRIME;
            end
            if (ev) m_last = ed;
            else    ed = m_last;
            m_pos++;
            if (m_pos == 2 * DELAY) begin
                m_pos = 0;
                m_primed = 1;
                for (int i = 0; i < DELAY; i++) m_diff[i] = m_next[i];
            end
        end
        @(posedge clk);
        #1;
        $display("txn v=%0d x=%0d -> valid_out=%0d phase_out=%0d data_out=%0d",
                 v, x, valid_out, phase_out, data_out);
        check("valid_out", 128'(valid_out), 128'(ev));
        check("data_out", data_out, ed);
        if (ev) check("phase_out", 128'(phase_out), 128'(ep));
    endtask

    task automatic check_reset_outputs();
        check("rst_valid", 128'(valid_out), 128'(0));
        check("rst_data", data_out, 128'(0));
        check("rst_phase", 128'(phase_out), 128'(0));
        check("rst_tw_addr", 128'(tw_addr), 128'(0));
    endtask

    initial begin
        model_reset();
        set_tw(0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs();
        rst_n = 1'b1;

        // Fill with 1..8, then drain: diffs 1-5 = 7677 emerge as products.
        for (int i = 1; i <= 8; i++) step(1, longint'(i));
        for (int i = 0; i < 8; i++) step(1, 0);

        // Same frame with twiddle PRIME-1: large unreduced products.
        set_tw(1);
        for (int i = 1; i <= 8; i++) step(1, longint'(i));
        for (int i = 0; i < 8; i++) step(1, 0);

        // Sum wrap to 0 and diff wrap to 1.
        set_tw(2);
        step(1, 7680); step(1, 0); step(1, 5); step(1, 9);
        step(1, 1);    step(1, 7680); step(1, 5); step(1, 2);
        for (int i = 0; i < 8; i++) step(1, 0);

        // Random frames with random valid_in gaps.
        for (int f = 0; f < 6; f++) begin
            set_tw(2);
            for (int i = 0; i < 2 * DELAY; i++) begin
                while ($urandom_range(0, 3) == 0) step(0, 64'($urandom));
                step(1, longint'($urandom_range(0, PRIME - 1)));
            end
        end
        for (int i = 0; i < 2 * DELAY; i++) begin
            if ($urandom_range(0, 2) == 0) step(0, 0);
            step(1, 0);
        end

        // Mid-frame asynchronous reset, then restart cleanly.
        set_tw(0);
        for (int i = 1; i <= 6; i++) step(1, longint'(i));
        @(negedge clk);
        valid_in = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= 8; i++) step(1, longint'(i));
        for (int i = 0; i < 4; i++) step(1, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
